prf_nr_mw: RTL and testbench

- Parametrised multi-entry physical register file; next generation of the single-entry 2-read/6-write priority flop.
- Generalises depth, width, read-port count and write-port count.
- Adds per-entry ready (valid) scoreboard bits, rename-allocation clearing, flush, optional write-to-read bypass, hardwired zero entry and write-conflict reporting.
- Sits between rename/issue (allocate, read) and the writeback buses (write) of the out-of-order core.

---
 rtl/prf_nr_mw_pkg.sv | 18 +
 rtl/prf_wr_arb.sv | 32 +++
 rtl/prf_nr_mw.sv | 141 ++++++++++++++
 tb/tb_prf_nr_mw.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prf_nr_mw_pkg.sv
`default_nettype none
// ============================================================================
// prf_nr_mw_pkg : shared PRF geometry used by rename, issue and writeback
// Rev 1.0
// ============================================================================
package prf_nr_mw_pkg;

    localparam int PRF_DATA_WIDTH  = 32;
    localparam int PRF_NUM_ENTRIES = 64;
    localparam int PRF_ADDR_W      = 6;
    localparam int PRF_NUM_RD      = 2;
    localparam int PRF_NUM_WR      = 6;

    typedef logic [PRF_ADDR_W-1:0]     prf_addr_t;
    typedef logic [PRF_DATA_WIDTH-1:0] prf_data_t;

endpackage
`default_nettype wire

// File: rtl/prf_wr_arb.sv
`default_nettype none
// ============================================================================
// prf_wr_arb : per-entry write priority encoder (port 0 wins), multi-hit flag
// Rev 1.0
// ============================================================================
module prf_wr_arb
    import prf_nr_mw_pkg::*;
#(
    parameter int NUM_WR     = PRF_NUM_WR,
    parameter int DATA_WIDTH = PRF_DATA_WIDTH
) (
    input  logic [NUM_WR-1:0]            match_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
    output logic                         hit_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         multi_o
);

    always_comb begin
        data_o = '0;
        // Walk from the lowest priority upward so the last assignment is port 0's.
        for (int k = NUM_WR - 1; k >= 0; k--) begin
            if (match_i[k]) begin
                data_o = wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        hit_o   = |match_i;
        multi_o = (match_i & (match_i - NUM_WR'(1))) != '0;
    end

endmodule
`default_nettype wire

// File: rtl/prf_nr_mw.sv
`default_nettype none
// ============================================================================
// prf_nr_mw : multi-entry, multi-port physical register file with ready bits
// Rev 1.0
// ============================================================================
module prf_nr_mw
    import prf_nr_mw_pkg::*;
#(
    parameter int DATA_WIDTH  = PRF_DATA_WIDTH,
    parameter int NUM_ENTRIES = PRF_NUM_ENTRIES,
    parameter int ADDR_W      = PRF_ADDR_W,
    parameter int NUM_RD      = PRF_NUM_RD,
    parameter int NUM_WR      = PRF_NUM_WR,
    parameter int BYPASS      = 1,
    parameter int ZERO_REG    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]     wr_addr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
    input  logic [NUM_RD-1:0]            rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]            rd_ready_o,
    input  logic                         alloc_en_i,
    input  logic [ADDR_W-1:0]            alloc_addr_i,
    input  logic                         flush_i,
    output logic                         wr_conflict_o
);

    logic [NUM_ENTRIES-1:0] w_hit;
    logic [NUM_ENTRIES-1:0] w_multi;
    logic [NUM_ENTRIES-1:0] w_rdy;
    logic [DATA_WIDTH-1:0]  w_wdata [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  w_mem   [NUM_ENTRIES];
    logic                   wr_conflict_q;

    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
        if (ZERO_REG != 0 && e == 0) begin : g_zero
            assign w_hit[e]   = 1'b0;
            assign w_multi[e] = 1'b0;
            assign w_wdata[e] = '0;
            assign w_mem[e]   = '0;
            assign w_rdy[e]   = 1'b1;
        end else begin : g_reg
            logic [NUM_WR-1:0]     match;
            logic                  alloc_hit;
            logic [DATA_WIDTH-1:0] data_q, data_d;
            logic                  rdy_q, rdy_d;

            always_comb begin
                match = '0;
                for (int k = 0; k < NUM_WR; k++) begin
                    match[k] = wr_en_i[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(e));
                end
            end

            prf_wr_arb #(
                .NUM_WR     (NUM_WR),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_arb (
                .match_i   (match),
                .wr_data_i (wr_data_i),
                .hit_o     (w_hit[e]),
                .data_o    (w_wdata[e]),
                .multi_o   (w_multi[e])
            );

            assign alloc_hit = alloc_en_i && (alloc_addr_i == ADDR_W'(e));

            // Ready priority: flush over allocate over write.
            always_comb begin
                data_d = w_hit[e] ? w_wdata[e] : data_q;
                rdy_d  = rdy_q;
                if (flush_i) begin
                    rdy_d = 1'b1;
                end else if (alloc_hit) begin
                    rdy_d = 1'b0;
                end else if (w_hit[e]) begin
                    rdy_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_q <= '0;
                    rdy_q  <= 1'b1;
                end else begin
                    data_q <= data_d;
                    rdy_q  <= rdy_d;
                end
            end

            assign w_mem[e] = data_q;
            assign w_rdy[e] = rdy_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= |w_multi;
        end
    end

    assign wr_conflict_o = wr_conflict_q;

    // Out-of-range addresses match no entry and fall through to 0 / not ready.
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0]     raddr;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  rrdy;

        assign raddr = rd_addr_i[j*ADDR_W +: ADDR_W];

        always_comb begin
            rdata = '0;
            rrdy  = 1'b0;
            if (rd_en_i[j]) begin
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    if (raddr == ADDR_W'(e)) begin
                        if (BYPASS != 0 && w_hit[e]) begin
                            rdata = w_wdata[e];
                            rrdy  = 1'b1;
                        end else begin
                            rdata = w_mem[e];
                            rrdy  = w_rdy[e];
                        end
                    end
                end
            end
        end

        assign rd_data_o[j*DATA_WIDTH +: DATA_WIDTH] = rdata;
        assign rd_ready_o[j]                          = rrdy;
    end

endmodule
`default_nettype wire

// File: tb/tb_prf_nr_mw.sv
`default_nettype none
// ============================================================================
// tb_prf_nr_mw : directed vectors plus randomized traffic against a PRF model
// Rev 1.0
// ============================================================================
module tb_prf_nr_mw;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 2;
    localparam int NW = 6;

    logic              clk;
    logic              rst;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data_a, rd_data_b;
    logic [NR-1:0]     rd_ready_a, rd_ready_b;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic              flush;
    logic              conf_a, conf_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance a: 64 entries with bypass; instance b: 48 entries, no bypass.
    prf_nr_mw dut (
        .clk(clk), .rst(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_a), .rd_ready_o(rd_ready_a),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .flush_i(flush),
        .wr_conflict_o(conf_a)
    );

    prf_nr_mw #(.NUM_ENTRIES(48), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_b), .rd_ready_o(rd_ready_b),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .flush_i(flush),
        .wr_conflict_o(conf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NW-1:0] t_wen;
    logic [AW-1:0] t_wa [NW];
    logic [DW-1:0] t_wd [NW];
    logic [NR-1:0] t_ren;
    logic [AW-1:0] t_ra [NR];
    logic          t_alloc;
    logic [AW-1:0] t_aaddr;
    logic          t_flush;

    logic [DW-1:0] m_data [2][64];
    logic          m_rdy  [2][64];
    logic          m_conf [2];

    typedef struct {
        int p0; int a0; logic [31:0] d0;
        int p1; int a1; logic [31:0] d1;
        int r0; int r1;
        int al; int aa; int fl;
        logic [31:0] x0; int y0; logic [31:0] x1; int y1; int xc;
    } vec_t;

    vec_t tbl [17];

    function automatic int nent(input int i);
        return (i == 0) ? 64 : 48;
    endfunction

    function automatic bit mvalid(input int i, input int a);
        return (a < nent(i)) && (a != 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear();
        t_wen   = '0;
        t_ren   = '1;
        t_alloc = 1'b0;
        t_aaddr = '0;
        t_flush = 1'b0;
        for (int k = 0; k < NW; k++) begin
            t_wa[k] = '0;
            t_wd[k] = '0;
        end
        for (int j = 0; j < NR; j++) t_ra[j] = '0;
    endtask

    task automatic drive();
        wr_en = t_wen;
        for (int k = 0; k < NW; k++) begin
            wr_addr[k*AW +: AW] = t_wa[k];
            wr_data[k*DW +: DW] = t_wd[k];
        end
        rd_en = t_ren;
        for (int j = 0; j < NR; j++) rd_addr[j*AW +: AW] = t_ra[j];
        alloc_en   = t_alloc;
        alloc_addr = t_aaddr;
        flush      = t_flush;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_conf[i] = 1'b0;
            for (int e = 0; e < 64; e++) begin
                m_data[i][e] = '0;
                m_rdy[i][e]  = 1'b1;
            end
        end
    endtask

    task automatic model_read(input int i, input int j, output logic [DW-1:0] d, output logic r);
        int a;
        bit found;
        a = int'(t_ra[j]);
        d = '0;
        r = 1'b0;
        found = 1'b0;
        if (t_ren[j] && mvalid(i, a)) begin
            d = m_data[i][a];
            r = m_rdy[i][a];
            if (i == 0) begin
                for (int k = 0; k < NW; k++) begin
                    if (!found && t_wen[k] && int'(t_wa[k]) == a) begin
                        d = t_wd[k];
                        r = 1'b1;
                        found = 1'b1;
                    end
                end
            end
        end else if (t_ren[j] && a == 0) begin
            r = 1'b1;
        end
    endtask

    task automatic model_step(input int i);
        bit wrote [64];
        bit c;
        int a;
        c = 1'b0;
        for (int e = 0; e < 64; e++) wrote[e] = 1'b0;
        for (int k = 0; k < NW; k++)
            for (int l = k + 1; l < NW; l++)
                if (t_wen[k] && t_wen[l] && t_wa[k] == t_wa[l] && mvalid(i, int'(t_wa[k])))
                    c = 1'b1;
        for (int k = 0; k < NW; k++) begin
            a = int'(t_wa[k]);
            if (t_wen[k] && mvalid(i, a) && !wrote[a]) begin
                m_data[i][a] = t_wd[k];
                wrote[a] = 1'b1;
            end
        end
        for (int e = 0; e < 64; e++) begin
            if (mvalid(i, e)) begin
                if (t_flush) m_rdy[i][e] = 1'b1;
                else if (t_alloc && int'(t_aaddr) == e) m_rdy[i][e] = 1'b0;
                else if (wrote[e]) m_rdy[i][e] = 1'b1;
            end
        end
        m_conf[i] = c;
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic pre();
        logic [DW-1:0] d;
        logic          r;
        drive();
        #2;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < NR; j++) begin
                model_read(i, j, d, r);
                chk($sformatf("mdl_data inst%0d port%0d", i, j),
                    (i == 0) ? rd_data_a[j*DW +: DW] : rd_data_b[j*DW +: DW], d);
                chk($sformatf("mdl_ready inst%0d port%0d", i, j),
                    32'((i == 0) ? rd_ready_a[j] : rd_ready_b[j]), 32'(r));
            end
        end
    endtask

    task automatic post();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("mdl_conflict inst0", 32'(conf_a), 32'(m_conf[0]));
        chk("mdl_conflict inst1", 32'(conf_b), 32'(m_conf[1]));
    endtask

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, 63));
    endfunction

    initial begin
        tbl[0]  = '{-1, 0, 0, -1, 0, 0, 5, 63, 0, 0, 0, 32'h0, 1, 32'h0, 1, 0};
        tbl[1]  = '{1, 7, 32'hAAAA0001, 4, 7, 32'hBBBB0004, 7, 7, 0, 0, 0, 32'hAAAA0001, 1, 32'hAAAA0001, 1, 1};
        tbl[2]  = '{-1, 0, 0, -1, 0, 0, 7, 7, 0, 0, 0, 32'hAAAA0001, 1, 32'hAAAA0001, 1, 0};
        tbl[3]  = '{2, 9, 32'h12345678, -1, 0, 0, 9, 10, 0, 0, 0, 32'h12345678, 1, 32'h0, 1, 0};
        tbl[4]  = '{0, 12, 32'hCAFEF00D, -1, 0, 0, 12, 9, 1, 12, 0, 32'hCAFEF00D, 1, 32'h12345678, 1, 0};
        tbl[5]  = '{-1, 0, 0, -1, 0, 0, 12, 12, 0, 0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 0};
        tbl[6]  = '{-1, 0, 0, -1, 0, 0, 12, 13, 1, 12, 1, 32'hCAFEF00D, 0, 32'h0, 1, 0};
        tbl[7]  = '{-1, 0, 0, -1, 0, 0, 12, 13, 0, 0, 0, 32'hCAFEF00D, 1, 32'h0, 1, 0};
        tbl[8]  = '{0, 0, 32'hFFFFFFFF, 3, 0, 32'h11111111, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 1, 0};
        tbl[9]  = '{-1, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 1, 0};
        tbl[10] = '{0, 4, 32'h44440004, 5, 5, 32'h55550005, 3, 4, 1, 3, 0, 32'h0, 1, 32'h44440004, 1, 0};
        tbl[11] = '{-1, 0, 0, -1, 0, 0, 3, 4, 1, 4, 0, 32'h0, 0, 32'h44440004, 1, 0};
        tbl[12] = '{-1, 0, 0, -1, 0, 0, 4, 5, 1, 5, 0, 32'h44440004, 0, 32'h55550005, 1, 0};
        tbl[13] = '{-1, 0, 0, -1, 0, 0, 3, 5, 0, 0, 1, 32'h0, 0, 32'h55550005, 0, 0};
        tbl[14] = '{-1, 0, 0, -1, 0, 0, 4, 5, 0, 0, 0, 32'h44440004, 1, 32'h55550005, 1, 0};
        tbl[15] = '{0, 63, 32'h63636363, 5, 63, 32'h0BAD0BAD, 3, 63, 0, 0, 0, 32'h0, 1, 32'h63636363, 1, 1};
        tbl[16] = '{-1, 0, 0, -1, 0, 0, 63, 3, 0, 0, 0, 32'h63636363, 1, 32'h0, 1, 0};

        rst = 1'b0;
        clear();
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int s = 0; s < 17; s++) begin
            clear();
            if (tbl[s].p0 >= 0) begin
                t_wen[tbl[s].p0] = 1'b1;
                t_wa[tbl[s].p0]  = AW'(tbl[s].a0);
                t_wd[tbl[s].p0]  = tbl[s].d0;
            end
            if (tbl[s].p1 >= 0) begin
                t_wen[tbl[s].p1] = 1'b1;
                t_wa[tbl[s].p1]  = AW'(tbl[s].a1);
                t_wd[tbl[s].p1]  = tbl[s].d1;
            end
            t_ra[0] = AW'(tbl[s].r0);
            t_ra[1] = AW'(tbl[s].r1);
            t_alloc = (tbl[s].al != 0);
            t_aaddr = AW'(tbl[s].aa);
            t_flush = (tbl[s].fl != 0);
            pre();
            chk($sformatf("vec%0d rd0 data", s), rd_data_a[31:0], tbl[s].x0);
            chk($sformatf("vec%0d rd0 ready", s), 32'(rd_ready_a[0]), 32'(tbl[s].y0));
            chk($sformatf("vec%0d rd1 data", s), rd_data_a[63:32], tbl[s].x1);
            chk($sformatf("vec%0d rd1 ready", s), 32'(rd_ready_a[1]), 32'(tbl[s].y1));
            post();
            chk($sformatf("vec%0d conflict", s), 32'(conf_a), 32'(tbl[s].xc));
        end

        // Bypass versus stored value on the same write.
        clear();
        t_wen[2] = 1'b1; t_wa[2] = 6'd9; t_wd[2] = 32'h87654321;
        t_ra[0] = 6'd9; t_ra[1] = 6'd50;
        pre();
        chk("byp rd data", rd_data_a[31:0], 32'h87654321);
        chk("nobyp rd data", rd_data_b[31:0], 32'h12345678);
        post();

        // Colliding writes to an address beyond the 48-entry instance.
        clear();
        t_wen[0] = 1'b1; t_wa[0] = 6'd50; t_wd[0] = 32'hDEADBEEF;
        t_wen[1] = 1'b1; t_wa[1] = 6'd50; t_wd[1] = 32'hDEADBEE1;
        t_ra[0] = 6'd9; t_ra[1] = 6'd50;
        pre();
        chk("nobyp rd9 committed", rd_data_b[31:0], 32'h87654321);
        chk("oor rd data", rd_data_b[63:32], 32'h0);
        chk("oor rd ready", 32'(rd_ready_b[1]), 32'h0);
        chk("inrange bypass 50", rd_data_a[63:32], 32'hDEADBEEF);
        post();
        chk("conflict entry 50 (64)", 32'(conf_a), 32'h1);
        chk("conflict entry 50 (48)", 32'(conf_b), 32'h0);

        clear();
        t_ra[0] = 6'd50; t_ra[1] = 6'd9; t_ren = 2'b01;
        pre();
        chk("stored 50 (64)", rd_data_a[31:0], 32'hDEADBEEF);
        chk("oor after write", rd_data_b[31:0], 32'h0);
        chk("oor ready after write", 32'(rd_ready_b[0]), 32'h0);
        chk("rd_en=0 data", rd_data_a[63:32], 32'h0);
        chk("rd_en=0 ready", 32'(rd_ready_a[1]), 32'h0);
        post();

        // Reset dropped mid-cycle with a write pending across an edge.
        clear();
        t_wen[0] = 1'b1; t_wa[0] = 6'd20; t_wd[0] = 32'h20202020;
        t_ra[0] = 6'd7; t_ra[1] = 6'd20;
        drive();
        #2;
        rst = 1'b0;
        #1;
        chk("async rst data", rd_data_a[31:0], 32'h0);
        chk("async rst ready", 32'(rd_ready_a[0]), 32'h1);
        chk("async rst conflict", 32'(conf_a), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear();
        t_ra[0] = 6'd20; t_ra[1] = 6'd7;
        pre();
        chk("no write survives rst", rd_data_a[31:0], 32'h0);
        chk("rst entry7 cleared", rd_data_b[63:32], 32'h0);
        post();

        for (int c = 0; c < 600; c++) begin
            clear();
            for (int k = 0; k < NW; k++) begin
                if ($urandom_range(0, 99) < 35) begin
                    t_wen[k] = 1'b1;
                    t_wa[k]  = raddr();
                    t_wd[k]  = DW'($urandom);
                end
            end
            for (int j = 0; j < NR; j++) begin
                t_ra[j]  = ($urandom_range(0, 2) == 0) ? t_wa[$urandom_range(0, NW - 1)] : raddr();
                t_ren[j] = ($urandom_range(0, 9) != 0);
            end
            t_alloc = ($urandom_range(0, 3) == 0);
            t_aaddr = ($urandom_range(0, 2) == 0) ? t_wa[$urandom_range(0, NW - 1)] : raddr();
            t_flush = ($urandom_range(0, 19) == 0);
            pre();
            post();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
